// File: rtl/tcdm_cmd_sched.sv
// Routes DMA channel commands onto the TCDM TX (read) and RX (write) command ports.
// Each direction has its own round-robin arbiter, one-entry output slot and outstanding limiter.
module tcdm_cmd_sched #(
    parameter int NB_CH           = 4,
    parameter int TRANS_SID_WIDTH = 1,
    parameter int TCDM_ADD_WIDTH  = 12,
    parameter int TCDM_OPC_WIDTH  = 12,
    parameter int MCHAN_LEN_WIDTH = 15,
    parameter int MAX_OUTST       = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NB_CH-1:0]                     ch_req_i,
    output logic [NB_CH-1:0]                     ch_gnt_o,
    input  logic [NB_CH*TRANS_SID_WIDTH-1:0]     ch_sid_i,
    input  logic [NB_CH*TCDM_ADD_WIDTH-1:0]      ch_add_i,
    input  logic [NB_CH*TCDM_OPC_WIDTH-1:0]      ch_opc_i,
    input  logic [NB_CH*MCHAN_LEN_WIDTH-1:0]     ch_len_i,
    output logic [TRANS_SID_WIDTH-1:0]           tcdm_tx_sid_o,
    output logic [TCDM_ADD_WIDTH-1:0]            tcdm_tx_add_o,
    output logic [TCDM_OPC_WIDTH-1:0]            tcdm_tx_opc_o,
    output logic [MCHAN_LEN_WIDTH-1:0]           tcdm_tx_len_o,
    output logic                                 tcdm_tx_req_o,
    input  logic                                 tcdm_tx_gnt_i,
    output logic [TRANS_SID_WIDTH-1:0]           tcdm_rx_sid_o,
    output logic [TCDM_ADD_WIDTH-1:0]            tcdm_rx_add_o,
    output logic [TCDM_OPC_WIDTH-1:0]            tcdm_rx_opc_o,
    output logic [MCHAN_LEN_WIDTH-1:0]           tcdm_rx_len_o,
    output logic                                 tcdm_rx_req_o,
    input  logic                                 tcdm_rx_gnt_i,
    input  logic                                 tx_synch_req_i,
    input  logic                                 rx_synch_req_i,
    output logic                                 tx_busy_o,
    output logic                                 rx_busy_o
);

    localparam int PW = (NB_CH > 1) ? $clog2(NB_CH) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int SW = TRANS_SID_WIDTH;
    localparam int AW = TCDM_ADD_WIDTH;
    localparam int OW = TCDM_OPC_WIDTH;
    localparam int LW = MCHAN_LEN_WIDTH;

    // Direction index: 0 = TX (TCDM read), 1 = RX (TCDM write)
    logic [NB_CH-1:0] dir_tx;
    logic [NB_CH-1:0] cand [2];
    logic [PW:0]      pick [2];
    logic [PW-1:0]    win [2];
    logic [PW-1:0]    ptr [2];
    logic [CW-1:0]    cnt [2];
    logic [1:0]       port_gnt, synch, slot_full, can_accept, grant, synch_orphan;
    logic [SW-1:0]    slot_sid [2];
    logic [AW-1:0]    slot_add [2];
    logic [OW-1:0]    slot_opc [2];
    logic [LW-1:0]    slot_len [2];

    // First candidate at or above ptr, wrapping; bit PW flags that one was found.
    function automatic logic [PW:0] rr_pick(input logic [NB_CH-1:0] c, input logic [PW-1:0] p);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int i = NB_CH - 1; i >= 0; i--) begin
            idx = (int'(p) + i) % NB_CH;
            if (c[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        dir_tx = '0;
        for (int k = 0; k < NB_CH; k++) dir_tx[k] = ch_opc_i[k*OW];
    end

    assign cand[0]  = ch_req_i & dir_tx;
    assign cand[1]  = ch_req_i & ~dir_tx;
    assign port_gnt = {tcdm_rx_gnt_i, tcdm_tx_gnt_i};
    assign synch    = {rx_synch_req_i, tx_synch_req_i};
    assign pick[0]  = rr_pick(cand[0], ptr[0]);
    assign pick[1]  = rr_pick(cand[1], ptr[1]);
    assign win[0]   = pick[0][PW-1:0];
    assign win[1]   = pick[1][PW-1:0];

    always_comb begin
        ch_gnt_o     = '0;
        can_accept   = '0;
        grant        = '0;
        synch_orphan = '0;
        for (int d = 0; d < 2; d++) begin
            // Synch is not credited here, so the limit can never be overshot.
            can_accept[d]   = (!slot_full[d] || port_gnt[d]) &&
                              ((int'(cnt[d]) + int'(slot_full[d])) < MAX_OUTST);
            grant[d]        = rst_ni && can_accept[d] && pick[d][PW];
            synch_orphan[d] = synch[d] && (cnt[d] == '0);
            if (grant[d]) ch_gnt_o[win[d]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_full <= '0;
            for (int d = 0; d < 2; d++) begin
                ptr[d]      <= '0;
                cnt[d]      <= '0;
                slot_sid[d] <= '0;
                slot_add[d] <= '0;
                slot_opc[d] <= '0;
                slot_len[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (grant[d]) begin
                    slot_full[d] <= 1'b1;
                    ptr[d]       <= (win[d] == PW'(NB_CH - 1)) ? '0 : win[d] + 1'b1;
                    slot_sid[d]  <= ch_sid_i[int'(win[d])*SW +: SW];
                    slot_add[d]  <= ch_add_i[int'(win[d])*AW +: AW];
                    slot_opc[d]  <= ch_opc_i[int'(win[d])*OW +: OW];
                    slot_len[d]  <= ch_len_i[int'(win[d])*LW +: LW];
                end else if (port_gnt[d]) begin
                    slot_full[d] <= 1'b0;
                end
                if (slot_full[d] && port_gnt[d] && !synch[d])
                    cnt[d] <= cnt[d] + 1'b1;
                else if (!(slot_full[d] && port_gnt[d]) && synch[d] && cnt[d] != '0)
                    cnt[d] <= cnt[d] - 1'b1;
            end
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!synch_orphan[0]) else $warning("tx synch pulse with no outstanding command");
            assert (!synch_orphan[1]) else $warning("rx synch pulse with no outstanding command");
        end
    end

    assign tcdm_tx_req_o = slot_full[0];
    assign tcdm_tx_sid_o = slot_sid[0];
    assign tcdm_tx_add_o = slot_add[0];
    assign tcdm_tx_opc_o = slot_opc[0];
    assign tcdm_tx_len_o = slot_len[0];
    assign tcdm_rx_req_o = slot_full[1];
    assign tcdm_rx_sid_o = slot_sid[1];
    assign tcdm_rx_add_o = slot_add[1];
    assign tcdm_rx_opc_o = slot_opc[1];
    assign tcdm_rx_len_o = slot_len[1];
    assign tx_busy_o     = slot_full[0] | (cnt[0] != '0);
    assign rx_busy_o     = slot_full[1] | (cnt[1] != '0);

endmodule

// File: tb/tb_tcdm_cmd_sched.sv
// Directed bench for tcdm_cmd_sched: arbitration order, limiter, stalls, counter edge cases, reset.
module tb_tcdm_cmd_sched;

    localparam int NB_CH = 4;
    localparam int SW = 1;
    localparam int AW = 12;
    localparam int OW = 12;
    localparam int LW = 15;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NB_CH-1:0]  ch_req_i = '0;
    logic [NB_CH-1:0]  ch_gnt_o;
    logic [NB_CH*SW-1:0] ch_sid_i;
    logic [NB_CH*AW-1:0] ch_add_i;
    logic [NB_CH*OW-1:0] ch_opc_i;
    logic [NB_CH*LW-1:0] ch_len_i;
    logic [SW-1:0] tcdm_tx_sid_o, tcdm_rx_sid_o;
    logic [AW-1:0] tcdm_tx_add_o, tcdm_rx_add_o;
    logic [OW-1:0] tcdm_tx_opc_o, tcdm_rx_opc_o;
    logic [LW-1:0] tcdm_tx_len_o, tcdm_rx_len_o;
    logic tcdm_tx_req_o, tcdm_rx_req_o;
    logic tcdm_tx_gnt_i = 1'b0, tcdm_rx_gnt_i = 1'b0;
    logic tx_synch_req_i = 1'b0, rx_synch_req_i = 1'b0;
    logic tx_busy_o, rx_busy_o;

    logic [SW-1:0] c_sid [NB_CH];
    logic [AW-1:0] c_add [NB_CH];
    logic [OW-1:0] c_opc [NB_CH];
    logic [LW-1:0] c_len [NB_CH];

    int n_chk = 0;
    int n_fail = 0;
    int n_acc;

    tcdm_cmd_sched dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ch_req_i(ch_req_i), .ch_gnt_o(ch_gnt_o),
        .ch_sid_i(ch_sid_i), .ch_add_i(ch_add_i), .ch_opc_i(ch_opc_i), .ch_len_i(ch_len_i),
        .tcdm_tx_sid_o(tcdm_tx_sid_o), .tcdm_tx_add_o(tcdm_tx_add_o),
        .tcdm_tx_opc_o(tcdm_tx_opc_o), .tcdm_tx_len_o(tcdm_tx_len_o),
        .tcdm_tx_req_o(tcdm_tx_req_o), .tcdm_tx_gnt_i(tcdm_tx_gnt_i),
        .tcdm_rx_sid_o(tcdm_rx_sid_o), .tcdm_rx_add_o(tcdm_rx_add_o),
        .tcdm_rx_opc_o(tcdm_rx_opc_o), .tcdm_rx_len_o(tcdm_rx_len_o),
        .tcdm_rx_req_o(tcdm_rx_req_o), .tcdm_rx_gnt_i(tcdm_rx_gnt_i),
        .tx_synch_req_i(tx_synch_req_i), .rx_synch_req_i(rx_synch_req_i),
        .tx_busy_o(tx_busy_o), .rx_busy_o(rx_busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    always_comb begin
        for (int k = 0; k < NB_CH; k++) begin
            ch_sid_i[k*SW +: SW] = c_sid[k];
            ch_add_i[k*AW +: AW] = c_add[k];
            ch_opc_i[k*OW +: OW] = c_opc[k];
            ch_len_i[k*LW +: LW] = c_len[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        ch_req_i = '0;
        tcdm_tx_gnt_i = 1'b0;
        tcdm_rx_gnt_i = 1'b0;
        tx_synch_req_i = 1'b0;
        rx_synch_req_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < NB_CH; k++) begin
            c_sid[k] = SW'(k);
            c_add[k] = AW'(12'h100 + k);
            c_opc[k] = '0;
            c_len[k] = LW'(15'h10 + k);
        end

        // reset state, requests present but no grant while in reset
        ch_req_i = 4'hF;
        tick();
        tick();
        #1;
        check("rst_tx_req", 32'(tcdm_tx_req_o), 0);
        check("rst_rx_req", 32'(tcdm_rx_req_o), 0);
        check("rst_gnt", 32'(ch_gnt_o), 0);
        check("rst_busy", {30'd0, tx_busy_o, rx_busy_o}, 0);
        check("rst_rx_add", 32'(tcdm_rx_add_o), 0);

        // four RX channels, port always granting
        do_reset();
        tcdm_rx_gnt_i = 1'b1;
        ch_req_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t1_gnt", 32'(ch_gnt_o), 32'(1) << i);
            check("t1_cnt", 32'(dut.cnt[1]), (i == 0) ? 0 : i - 1);
            if (i > 0) check("t1_rx_add", 32'(tcdm_rx_add_o), 32'h100 + i - 1);
            tick();
            ch_req_i[i] = 1'b0;
        end
        #1;
        check("t1_rx_req_last", 32'(tcdm_rx_req_o), 1);
        check("t1_rx_add_last", 32'(tcdm_rx_add_o), 32'h103);
        tick();
        #1;
        check("t1_cnt_final", 32'(dut.cnt[1]), 4);
        check("t1_rx_req_idle", 32'(tcdm_rx_req_o), 0);
        check("t1_rx_busy", 32'(rx_busy_o), 1);
        check("t1_tx_busy", 32'(tx_busy_o), 0);

        // limiter: ch0 streams TX with no synch
        do_reset();
        c_opc[0] = 12'h001;
        tcdm_tx_gnt_i = 1'b1;
        ch_req_i = 4'b0001;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (ch_gnt_o[0]) n_acc++;
            tick();
        end
        #1;
        check("t2_accepted", 32'(n_acc), 4);
        check("t2_gnt_blocked", 32'(ch_gnt_o), 0);
        check("t2_cnt", 32'(dut.cnt[0]), 4);
        check("t2_tx_req", 32'(tcdm_tx_req_o), 0);
        tx_synch_req_i = 1'b1;
        #1;
        check("t2_gnt_during_synch", 32'(ch_gnt_o), 0);
        tick();
        tx_synch_req_i = 1'b0;
        #1;
        check("t2_cnt_after_synch", 32'(dut.cnt[0]), 3);
        check("t2_fifth_gnt", 32'(ch_gnt_o), 1);
        tick();
        ch_req_i = '0;
        #1;
        check("t2_fifth_req", 32'(tcdm_tx_req_o), 1);

        // simultaneous TX and RX grants
        do_reset();
        c_opc[0] = 12'h000;
        c_opc[1] = 12'h001;
        c_add[1] = 12'h311;
        c_opc[2] = 12'h000;
        c_add[2] = 12'h322;
        ch_req_i = 4'b0110;
        #1;
        check("t3_gnt", 32'(ch_gnt_o), 32'b0110);
        tick();
        ch_req_i = '0;
        #1;
        check("t3_tx_add", 32'(tcdm_tx_add_o), 32'h311);
        check("t3_rx_add", 32'(tcdm_rx_add_o), 32'h322);
        check("t3_reqs", {30'd0, tcdm_tx_req_o, tcdm_rx_req_o}, 32'b11);
        check("t3_tx_len", 32'(tcdm_tx_len_o), 32'h11);
        check("t3_tx_opc", 32'(tcdm_tx_opc_o), 32'h001);

        // TX port stall with slot full
        do_reset();
        c_opc[0] = 12'h001;
        c_add[0] = 12'h4A0;
        ch_req_i = 4'b0001;
        #1;
        check("t4_first_gnt", 32'(ch_gnt_o), 1);
        tick();
        c_add[0] = 12'h4A1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_stall_add", 32'(tcdm_tx_add_o), 32'h4A0);
            check("t4_stall_gnt", 32'(ch_gnt_o), 0);
            tick();
        end
        tcdm_tx_gnt_i = 1'b1;
        #1;
        check("t4_refill_gnt", 32'(ch_gnt_o), 1);
        tick();
        ch_req_i = '0;
        tcdm_tx_gnt_i = 1'b0;
        #1;
        check("t4_next_add", 32'(tcdm_tx_add_o), 32'h4A1);
        check("t4_next_req", 32'(tcdm_tx_req_o), 1);
        check("t4_cnt", 32'(dut.cnt[0]), 1);

        // counter: increment with synch, then synch underflow attempt
        do_reset();
        tcdm_tx_gnt_i = 1'b1;
        ch_req_i = 4'b0001;
        tick();
        tick();
        tick();
        ch_req_i = '0;
        tx_synch_req_i = 1'b1;
        #1;
        check("t5_cnt_before", 32'(dut.cnt[0]), 2);
        check("t5_req_before", 32'(tcdm_tx_req_o), 1);
        tick();
        #1;
        check("t5_cnt_inc_synch", 32'(dut.cnt[0]), 2);
        check("t5_req_drained", 32'(tcdm_tx_req_o), 0);
        tick();
        tick();
        #1;
        check("t5_cnt_zero", 32'(dut.cnt[0]), 0);
        check("t5_orphan_flag", 32'(dut.synch_orphan[0]), 1);
        tick();
        tx_synch_req_i = 1'b0;
        #1;
        check("t5_cnt_no_underflow", 32'(dut.cnt[0]), 0);
        check("t5_tx_busy", 32'(tx_busy_o), 0);

        // reset mid-stream, then priority restarts at ch0
        do_reset();
        tcdm_tx_gnt_i = 1'b1;
        ch_req_i = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        #1;
        check("t6_cnt_before", 32'(dut.cnt[0]), 3);
        check("t6_req_before", 32'(tcdm_tx_req_o), 1);
        c_opc[2] = 12'h001;
        c_add[2] = 12'h622;
        ch_req_i = 4'b0101;
        rst_ni = 1'b0;
        #1;
        check("t6_req_in_rst", 32'(tcdm_tx_req_o), 0);
        check("t6_busy_in_rst", 32'(tx_busy_o), 0);
        check("t6_gnt_in_rst", 32'(ch_gnt_o), 0);
        check("t6_cnt_in_rst", 32'(dut.cnt[0]), 0);
        tick();
        rst_ni = 1'b1;
        #1;
        check("t6_priority_ch0", 32'(ch_gnt_o), 1);
        tick();
        ch_req_i = '0;
        #1;
        check("t6_add_ch0", 32'(tcdm_tx_add_o), 32'h4A1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
